// File: rtl/switch_box_param.sv
// Runtime-configurable CGRA switch box: every output track picks the same-numbered
// track from one of the other three sides or the local PE, optionally through a register.
module switch_box_param #(
    parameter  int unsigned TRACKS = 4,
    parameter  int unsigned WIDTH  = 1,
    localparam int unsigned AW     = $clog2(4 * TRACKS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [4*TRACKS*WIDTH-1:0]   in_wire,
    output logic [4*TRACKS*WIDTH-1:0]   out_wire,
    input  logic [WIDTH-1:0]            pe_output_0,
    input  logic                        sb_ce,
    input  logic                        config_en,
    input  logic [AW-1:0]               config_addr,
    input  logic [31:0]                 config_data,
    output logic [31:0]                 config_rd_data
);

    localparam int unsigned ENTRIES = 4 * TRACKS;

    logic [1:0]       sel_q    [ENTRIES];
    logic             reg_en_q [ENTRIES];
    logic [WIDTH-1:0] pipe_q   [ENTRIES];
    logic [WIDTH-1:0] mux_c    [ENTRIES];
    logic             addr_ok_c;
    logic             unused_cfg_bits;

    assign addr_ok_c       = 32'(config_addr) < ENTRIES;
    assign unused_cfg_bits = ^config_data[31:3];

    // Source side for sel 0..2 is (side + sel + 1) mod 4, so a side never feeds itself.
    always_comb begin
        out_wire = '0;
        for (int o = 0; o < int'(ENTRIES); o++) begin
            mux_c[o] = pe_output_0;
            if (sel_q[o] != 2'd3) begin
                mux_c[o] = in_wire[((((o / TRACKS) + 32'(sel_q[o]) + 1) % 4) * TRACKS
                                    + (o % TRACKS)) * WIDTH +: WIDTH];
            end
            out_wire[o*WIDTH +: WIDTH] = reg_en_q[o] ? pipe_q[o] : mux_c[o];
        end
    end

    // Config entries, output pipes and readback; reset overrides a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < int'(ENTRIES); o++) begin
                sel_q[o]    <= 2'd0;
                reg_en_q[o] <= 1'b0;
                pipe_q[o]   <= '0;
            end
            config_rd_data <= 32'd0;
        end else begin
            if (sb_ce) begin
                for (int o = 0; o < int'(ENTRIES); o++) begin
                    pipe_q[o] <= mux_c[o];
                end
            end
            if (config_en && addr_ok_c) begin
                sel_q[config_addr]    <= config_data[1:0];
                reg_en_q[config_addr] <= config_data[2];
            end
            config_rd_data <= addr_ok_c ? {29'd0, reg_en_q[config_addr], sel_q[config_addr]}
                                        : 32'd0;
        end
    end

endmodule

// File: tb/tb_switch_box_param.sv
// Bench for switch_box_param (TRACKS=3, WIDTH=8): per-cycle model comparison plus
// directed scenarios with hand-computed literal expectations.
module tb_switch_box_param;

    localparam int unsigned T  = 3;
    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4 * T;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned BW = N * W;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] in_wire;
    logic [BW-1:0] out_wire;
    logic [W-1:0]  pe_output_0;
    logic          sb_ce;
    logic          config_en;
    logic [AW-1:0] config_addr;
    logic [31:0]   config_data;
    logic [31:0]   config_rd_data;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    switch_box_param #(.TRACKS(T), .WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_wire        (in_wire),
        .out_wire       (out_wire),
        .pe_output_0    (pe_output_0),
        .sb_ce          (sb_ce),
        .config_en      (config_en),
        .config_addr    (config_addr),
        .config_data    (config_data),
        .config_rd_data (config_rd_data)
    );

    // Behavioural model: configuration table, pipe contents and last readback.
    logic [1:0]  m_sel  [N];
    logic        m_reg  [N];
    logic [7:0]  m_pipe [N];
    logic [7:0]  m_nxt  [N];
    logic [31:0] m_rd;

    function automatic logic [7:0] route(input int o);
        int s;
        int t;
        int src;
        s = o / T;
        t = o % T;
        if (m_sel[o] == 2'd3) return pe_output_0;
        src = (s + 1 + int'(m_sel[o])) % 4;
        return in_wire[(src * T + t) * W +: W];
    endfunction

    function automatic logic [BW-1:0] exp_out();
        logic [BW-1:0] v;
        v = '0;
        for (int o = 0; o < N; o++) v[o*W +: W] = m_reg[o] ? m_pipe[o] : route(o);
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < N; o++) begin
                m_sel[o] = 2'd0; m_reg[o] = 1'b0; m_pipe[o] = 8'd0;
            end
            m_rd = 32'd0;
        end else begin
            for (int o = 0; o < N; o++) m_nxt[o] = route(o);
            m_rd = (int'(config_addr) < N) ? {29'd0, m_reg[config_addr], m_sel[config_addr]} : 32'd0;
            if (sb_ce) for (int o = 0; o < N; o++) m_pipe[o] = m_nxt[o];
            if (config_en && int'(config_addr) < N) begin
                m_sel[config_addr] = config_data[1:0];
                m_reg[config_addr] = config_data[2];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (out_wire !== exp_out()) begin
                failures++;
                $display("FAIL model_out t=%0t act=%h exp=%h", $time, out_wire, exp_out());
            end
            checks++;
            if (config_rd_data !== m_rd) begin
                failures++;
                $display("FAIL model_rd t=%0t act=%h exp=%h", $time, config_rd_data, m_rd);
            end
        end
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] data);
        config_en   = 1'b1;
        config_addr = AW'(addr);
        config_data = data;
        step();
        config_en   = 1'b0;
    endtask

    function automatic logic [BW-1:0] byte_of(input int o);
        return BW'(out_wire[o*W +: W]);
    endfunction

    task automatic set_pattern();
        for (int s = 0; s < 4; s++)
            for (int t = 0; t < T; t++) in_wire[(s*T + t)*W +: W] = 8'(16*s + t);
    endtask

    initial begin
        int exp_b;
        reset = 1'b1; sb_ce = 1'b1; config_en = 1'b0; config_addr = '0; config_data = '0;
        pe_output_0 = 8'h00;
        in_wire = '0;
        in_wire[(1*T + 2)*W +: W] = 8'h01;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_out", out_wire, BW'(96'h01_0000));
        chk("reset_rd", BW'(config_rd_data), '0);

        // Routing sweep over every output and every select.
        set_pattern();
        pe_output_0 = 8'hAA;
        for (int o = 0; o < N; o++) begin
            for (int sel = 0; sel < 4; sel++) begin
                cfg_write(o, 32'(sel));
                exp_b = (sel == 3) ? 8'hAA : 16*(((o / T) + 1 + sel) % 4) + (o % T);
                chk("sweep_out", byte_of(o), BW'(exp_b));
                step();
                chk("sweep_rd", BW'(config_rd_data), BW'(sel));
            end
        end
        cfg_write(1, 32'd2);  chk("route_o1_s2", byte_of(1), BW'(8'h31));
        cfg_write(6, 32'd0);  chk("route_o6_s0", byte_of(6), BW'(8'h30));
        cfg_write(4, 32'd3);  chk("route_o4_pe", byte_of(4), BW'(8'hAA));

        // Registered PE path on output 5; upper config bits must be ignored.
        cfg_write(5, 32'hFFFF_FFFF);
        pe_output_0 = 8'h11; step();
        chk("cfg_rd_masked", BW'(config_rd_data), BW'(32'd7));
        pe_output_0 = 8'h22; chk("reg_lag1", byte_of(5), BW'(8'h11)); step();
        pe_output_0 = 8'h33; sb_ce = 1'b0; chk("reg_lag2", byte_of(5), BW'(8'h22)); step();
        pe_output_0 = 8'h44; chk("reg_hold1", byte_of(5), BW'(8'h22)); step();
        chk("reg_hold2", byte_of(5), BW'(8'h22));
        sb_ce = 1'b1;

        // Boundary addresses.
        cfg_write(11, 32'd1);
        chk("addr_last", byte_of(11), BW'(8'h12));
        cfg_write(12, 32'd7);
        step();
        chk("addr_oob_rd", BW'(config_rd_data), '0);

        // Same-cycle write and read.
        cfg_write(4, 32'd2);
        cfg_write(4, 32'd1);
        chk("rw_old", BW'(config_rd_data), BW'(32'd2));
        step();
        chk("rw_new", BW'(config_rd_data), BW'(32'd1));

        // Reset wins over a write; pipes are cleared.
        sb_ce = 1'b0;
        reset = 1'b1; config_en = 1'b1; config_addr = AW'(7); config_data = 32'd6;
        step();
        reset = 1'b0; config_en = 1'b0;
        step();
        chk("rst_wr_rd", BW'(config_rd_data), '0);
        chk("rst_wr_out", byte_of(7), BW'(8'h31));
        cfg_write(0, 32'd4);
        chk("pipe_cleared", byte_of(0), '0);
        sb_ce = 1'b1;

        // Mid-operation reset after all outputs registered from PE.
        for (int o = 0; o < N; o++) cfg_write(o, 32'd7);
        pe_output_0 = 8'h5A;
        step();
        chk("all_reg_pe", out_wire, {N{8'h5A}});
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_out", out_wire, BW'(96'h020100_323130_222120_121110));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
